core_scheduler: RTL and testbench

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/gpu_pkg.sv | 20 ++
 rtl/wait_watchdog.sv | 31 +++
 rtl/core_scheduler.sv | 132 +++++++++++++
 tb/tb_core_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared core-level definitions: state encoding and datapath widths.
package gpu_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned PC_W    = 8;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned WDOG_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_REQUEST = 3'd3,
        ST_WAIT    = 3'd4,
        ST_EXECUTE = 3'd5,
        ST_UPDATE  = 3'd6,
        ST_DONE    = 3'd7
    } core_state_e;

endpackage

// File: rtl/wait_watchdog.sv
// WAIT-state watchdog. The counter holds the number of WAIT cycles already
// completed. expired flags the WAIT_LIMIT-th enabled cycle.
module wait_watchdog
    import gpu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WDOG_W-1:0] count;

    // Cycle counter: cleared on WAIT entry, saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {WDOG_W{1'b1}})) begin
            count <= count + WDOG_W'(1);
        end
    end

    // The current cycle is the limit-th one when completed + 1 reaches the limit.
    assign expired = enable && ((32'(count) + 32'd1) >= WAIT_LIMIT);

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction scheduler: walks each instruction through
// FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE and tracks the shared PC.
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int unsigned THREADS    = 4,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [THREADS-1:0]  thread_mask,
    input  logic                fetch_done,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                ProgramEnd,
    input  logic [THREADS-1:0]  lsu_busy,
    input  logic [PC_W-1:0]     next_pc,
    output logic [STATE_W-1:0]  core_state,
    output logic [PC_W-1:0]     current_pc,
    output logic                fetch_req,
    output logic                lsu_req,
    output logic                done,
    output logic                timeout,
    output logic [COUNT_W-1:0]  instr_count
);

    core_state_e state;
    core_state_e state_next;
    logic        wait_ready;
    logic        wait_clear;
    logic        wait_enable;
    logic        wd_expired;

    // Only busy lanes belonging to active threads can hold the core in WAIT.
    assign wait_ready = ((lsu_busy & thread_mask) == '0);

    wait_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .enable  (wait_enable),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completion of the memory op wins over a same-cycle expiry.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_FETCH;
            ST_FETCH:   if (fetch_done) state_next = ST_DECODE;
            ST_DECODE:  state_next = ST_REQUEST;
            ST_REQUEST: state_next = ST_WAIT;
            ST_WAIT: begin
                if (wait_ready) begin
                    state_next = ST_EXECUTE;
                end else if (wd_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_EXECUTE: state_next = ST_UPDATE;
            ST_UPDATE:  state_next = ProgramEnd ? ST_DONE : ST_FETCH;
            ST_DONE:    state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs and watchdog controls.
    always_comb begin
        core_state  = state;
        fetch_req   = 1'b0;
        lsu_req     = 1'b0;
        done        = 1'b0;
        wait_clear  = 1'b0;
        wait_enable = 1'b0;
        case (state)
            ST_FETCH:   fetch_req = 1'b1;
            ST_REQUEST: begin
                lsu_req    = MemRead | MemWrite;
                wait_clear = 1'b1;
            end
            ST_WAIT:    wait_enable = 1'b1;
            ST_DONE:    done = 1'b1;
            default:    ;
        endcase
    end

    // PC, retired-instruction counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            current_pc  <= '0;
            instr_count <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        current_pc  <= '0;
                        instr_count <= '0;
                        timeout     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!wait_ready && wd_expired) begin
                        timeout <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (!ProgramEnd) begin
                        current_pc <= next_pc;
                    end
                    if (instr_count != {COUNT_W{1'b1}}) begin
                        instr_count <= instr_count + COUNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_scheduler.sv
// Randomised self-checking bench for core_scheduler. Each instruction is
// described by its fetch latency, stall length and decode flags; the model
// expands that into the expected per-cycle state list plus final PC/count.
module tb_core_scheduler;

    localparam int unsigned THREADS    = 4;
    localparam int unsigned WAIT_LIMIT = 255;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_REQUEST = 3;
    localparam int S_WAIT = 4, S_EXECUTE = 5, S_UPDATE = 6, S_DONE = 7;

    logic                clk;
    logic                reset;
    logic                start;
    logic [THREADS-1:0]  thread_mask;
    logic                fetch_done;
    logic                MemRead;
    logic                MemWrite;
    logic                ProgramEnd;
    logic [THREADS-1:0]  lsu_busy;
    logic [7:0]          next_pc;
    logic [2:0]          core_state;
    logic [7:0]          current_pc;
    logic                fetch_req;
    logic                lsu_req;
    logic                done;
    logic                timeout;
    logic [15:0]         instr_count;

    int checks   = 0;
    int failures = 0;
    int model_pc;
    int model_cnt;
    bit model_to;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    core_scheduler #(
        .THREADS    (THREADS),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .thread_mask (thread_mask),
        .fetch_done  (fetch_done),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .ProgramEnd  (ProgramEnd),
        .lsu_busy    (lsu_busy),
        .next_pc     (next_pc),
        .core_state  (core_state),
        .current_pc  (current_pc),
        .fetch_req   (fetch_req),
        .lsu_req     (lsu_req),
        .done        (done),
        .timeout     (timeout),
        .instr_count (instr_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs;
        start       = 1'($urandom);
        thread_mask = 4'($urandom);
        fetch_done  = 1'($urandom);
        MemRead     = 1'($urandom);
        MemWrite    = 1'($urandom);
        ProgramEnd  = 1'($urandom);
        lsu_busy    = 4'($urandom);
        next_pc     = 8'($urandom);
    endtask

    // Reset with garbage on every input, then release with start low.
    task automatic test_reset;
        reset = 1'b0;
        randomize_inputs();
        start = 1'b1;
        tick();
        checks++;
        if (core_state !== 3'(S_IDLE)) begin
            failures++; $display("FAIL reset_state got=%0d exp=%0d", core_state, S_IDLE);
        end
        checks++;
        if (current_pc !== 8'd0 || instr_count !== 16'd0) begin
            failures++; $display("FAIL reset_regs pc=%0d cnt=%0d exp=0/0", current_pc, instr_count);
        end
        checks++;
        if ({fetch_req, lsu_req, done, timeout} !== 4'b0000) begin
            failures++; $display("FAIL reset_outs got=%b exp=0000", {fetch_req, lsu_req, done, timeout});
        end
        reset = 1'b1;
        start = 1'b0;
        tick();
        checks++;
        if (core_state !== 3'(S_IDLE)) begin
            failures++; $display("FAIL idle_hold got=%0d exp=%0d", core_state, S_IDLE);
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start     = 1'b0;
        model_pc  = 0;
        model_cnt = 0;
        model_to  = 1'b0;
    endtask

    // Runs one instruction starting in FETCH; stall = WAIT cycles with an
    // active thread busy (>= WAIT_LIMIT means never released). bpat, when
    // non-zero, fixes the busy pattern instead of a random one.
    task automatic run_instr(input int f, input int stall, input logic [3:0] mask,
                             input logic rd, input logic wr, input logic pe,
                             input logic [7:0] npc, input logic [3:0] bpat);
        int q[$];
        int waits;
        bit to;
        int fi;
        int wi;
        int e;
        int exp_next;
        logic [3:0] lowbit;
        to    = (mask != 4'd0) && (stall >= int'(WAIT_LIMIT));
        waits = (mask == 4'd0) ? 1 : (to ? int'(WAIT_LIMIT) : stall + 1);
        for (int i = 0; i <= f; i++) q.push_back(S_FETCH);
        q.push_back(S_DECODE);
        q.push_back(S_REQUEST);
        for (int i = 0; i < waits; i++) q.push_back(S_WAIT);
        if (!to) begin
            q.push_back(S_EXECUTE);
            q.push_back(S_UPDATE);
        end
        lowbit = mask & (~mask + 4'd1);
        fi = 0;
        wi = 0;
        thread_mask = mask;
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            start      = 1'($urandom);
            fetch_done = (e == S_FETCH) ? (fi == f) : 1'($urandom);
            MemRead    = (e == S_REQUEST) ? rd : 1'($urandom);
            MemWrite   = (e == S_REQUEST) ? wr : 1'($urandom);
            ProgramEnd = (e == S_UPDATE) ? pe : 1'($urandom);
            next_pc    = (e == S_UPDATE) ? npc : 8'($urandom);
            if (e == S_WAIT && mask != 4'd0 && (to || wi < stall)) begin
                lsu_busy = (bpat != 4'd0) ? bpat : (4'($urandom) | lowbit);
            end else if (e == S_WAIT) begin
                lsu_busy = (bpat != 4'd0) ? (bpat & ~mask) : (4'($urandom) & ~mask);
            end else begin
                lsu_busy = 4'($urandom);
            end
            #1;
            checks++;
            if (core_state !== 3'(e)) begin
                failures++; $display("FAIL state cyc=%0d got=%0d exp=%0d", i, core_state, e);
            end
            checks++;
            if (fetch_req !== (e == S_FETCH) || done !== 1'b0 || timeout !== 1'b0) begin
                failures++; $display("FAIL ctrl cyc=%0d fetch_req=%b done=%b timeout=%b exp_fetch=%b",
                                     i, fetch_req, done, timeout, (e == S_FETCH));
            end
            checks++;
            if (lsu_req !== ((e == S_REQUEST) && (rd || wr))) begin
                failures++; $display("FAIL lsu_req cyc=%0d got=%b exp=%b", i, lsu_req, ((e == S_REQUEST) && (rd || wr)));
            end
            checks++;
            if (current_pc !== 8'(model_pc)) begin
                failures++; $display("FAIL pc_hold cyc=%0d got=%0d exp=%0d", i, current_pc, model_pc);
            end
            if (e == S_FETCH) fi++;
            if (e == S_WAIT) wi++;
            tick();
        end
        if (to) begin
            model_to = 1'b1;
        end else begin
            model_cnt = (model_cnt < 65535) ? model_cnt + 1 : 65535;
            if (!pe) model_pc = int'(npc);
        end
        exp_next = (to || pe) ? S_DONE : S_FETCH;
        #1;
        checks++;
        if (core_state !== 3'(exp_next) || done !== (exp_next == S_DONE)) begin
            failures++; $display("FAIL after_instr state=%0d done=%b exp_state=%0d", core_state, done, exp_next);
        end
        checks++;
        if (current_pc !== 8'(model_pc) || instr_count !== 16'(model_cnt) || timeout !== model_to) begin
            failures++; $display("FAIL after_regs pc=%0d cnt=%0d to=%b exp=%0d/%0d/%b",
                                 current_pc, instr_count, timeout, model_pc, model_cnt, model_to);
        end
    endtask

    // DONE must hold with start asserted and registers frozen.
    task automatic check_done_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            randomize_inputs();
            start = 1'b1;
            tick();
            checks++;
            if (core_state !== 3'(S_DONE) || done !== 1'b1 || timeout !== model_to ||
                current_pc !== 8'(model_pc) || instr_count !== 16'(model_cnt)) begin
                failures++; $display("FAIL done_hold st=%0d done=%b to=%b pc=%0d cnt=%0d exp_pc=%0d exp_cnt=%0d",
                                     core_state, done, timeout, current_pc, instr_count, model_pc, model_cnt);
            end
        end
    endtask

    task automatic test_add;
        test_reset();
        do_start();
        run_instr(2, 0, 4'($urandom), 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    endtask

    task automatic test_load_stall;
        run_instr(0, 4, 4'b1111, 1'b1, 1'b0, 1'b0, 8'd2, 4'b0101);
    endtask

    task automatic test_masked_busy;
        run_instr(1, 0, 4'b0011, 1'b0, 1'b1, 1'b0, 8'd7, 4'b1100);
    endtask

    task automatic test_return;
        run_instr(0, 0, 4'b1111, 1'b0, 1'b0, 1'b1, 8'd33, 4'd0);
        check_done_hold(4);
    endtask

    task automatic test_pc_wrap;
        test_reset();
        do_start();
        run_instr(0, 1, 4'b0110, 1'b1, 1'b1, 1'b0, 8'd255, 4'd0);
        run_instr(1, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    endtask

    task automatic test_timeout;
        test_reset();
        do_start();
        run_instr(0, int'(WAIT_LIMIT), 4'b1111, 1'b1, 1'b0, 1'b0, 8'd9, 4'b0001);
        check_done_hold(3);
    endtask

    task automatic test_reset_mid_wait;
        test_reset();
        do_start();
        run_instr(0, 0, 4'b1111, 1'b0, 1'b0, 1'b0, 8'd200, 4'd0);
        thread_mask = 4'b1111;
        lsu_busy    = 4'b1111;
        fetch_done  = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (core_state !== 3'(S_WAIT)) begin
            failures++; $display("FAIL pre_reset_wait got=%0d exp=%0d", core_state, S_WAIT);
        end
        reset = 1'b0;
        start = 1'b1;
        tick();
        checks++;
        if (core_state !== 3'(S_IDLE) || current_pc !== 8'd0 || instr_count !== 16'd0) begin
            failures++; $display("FAIL mid_wait_reset st=%0d pc=%0d cnt=%0d exp=0/0/0", core_state, current_pc, instr_count);
        end
        reset = 1'b1;
        do_start();
        run_instr(1, 2, 4'b1000, 1'b1, 1'b0, 1'b0, 8'd5, 4'd0);
    endtask

    task automatic test_random;
        int f;
        int stall;
        bit pe;
        test_reset();
        do_start();
        for (int n = 0; n < 40; n++) begin
            f     = $urandom_range(0, 3);
            stall = $urandom_range(0, 6);
            pe    = ($urandom_range(0, 9) == 0);
            run_instr(f, stall, 4'($urandom), 1'($urandom), 1'($urandom), pe, 8'($urandom), 4'd0);
            if (pe) begin
                check_done_hold(2);
                test_reset();
                do_start();
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        randomize_inputs();
        tick();
        test_reset();
        test_add();
        test_load_stall();
        test_masked_busy();
        test_return();
        test_pc_wrap();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
